// File: rtl/cpu_run_trace_ctrl_pkg.sv
// rtl/cpu_run_trace_ctrl_pkg.sv - shared types and trace view helper for the run/trace controller
package cpu_run_trace_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_FAULT
    } run_state_t;

    typedef enum logic [1:0] {
        NONE,
        USER,
        BKPT,
        FAULT
    } stop_cause_t;

    // A capture pushes the viewed entry one slot older; navigation then moves within the filled range.
    function automatic int next_view_offset(
        input int   offset,
        input int   count_after,
        input int   depth,
        input logic capture,
        input logic prev,
        input logic next
    );
        int off;
        off = offset;
        if (capture && off != 0) begin
            off = (off + 1 > depth - 1) ? depth - 1 : off + 1;
        end
        if (prev && !next && off < count_after - 1) begin
            off = off + 1;
        end else if (next && !prev && off > 0) begin
            off = off - 1;
        end
        if (off > count_after - 1) begin
            off = count_after - 1;
        end
        if (off < 0) begin
            off = 0;
        end
        return off;
    endfunction

endpackage

// File: rtl/cpu_run_trace_ctrl_edge_pulse.sv
// rtl/cpu_run_trace_ctrl_edge_pulse.sv - synchronous rising-edge detector for debounced button levels
module edge_pulse #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/cpu_run_trace_ctrl.sv
// rtl/cpu_run_trace_ctrl.sv - stackCPU run/step controller with scrollable retired-result trace
module cpu_run_trace_ctrl
    import cpu_run_trace_ctrl_pkg::*;
#(
    parameter int PC_WIDTH         = 8,
    parameter int INSTR_WIDTH      = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 8,
    parameter int CLK_FREQUENCY_HZ = 8000000,
    parameter int RUN_RATE_HZ      = 4,
    parameter int SIMULATE         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_step,
    input  logic                     btn_run,
    input  logic                     btn_prev,
    input  logic                     btn_next,
    input  logic                     bkpt_en,
    input  logic [PC_WIDTH-1:0]      bkpt_pc,
    input  logic [PC_WIDTH-1:0]      cpu_pc,
    input  logic [INSTR_WIDTH-1:0]   cpu_instruction,
    input  logic [DATA_WIDTH-1:0]    cpu_result,
    input  logic                     cpu_valid_result,
    input  logic                     cpu_halt,
    input  logic                     cpu_error,
    output logic                     single_step,
    output logic                     running,
    output logic [1:0]               stop_cause,
    output logic [PC_WIDTH-1:0]      view_pc,
    output logic [INSTR_WIDTH-1:0]   view_instruction,
    output logic [DATA_WIDTH-1:0]    view_result,
    output logic [$clog2(DEPTH)-1:0] view_offset,
    output logic                     view_live,
    output logic                     new_result
);

    localparam int OW  = $clog2(DEPTH);
    localparam int CW  = OW + 1;
    localparam int DIV = (SIMULATE != 0) ? 4 : CLK_FREQUENCY_HZ / RUN_RATE_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0]  result;
    } trace_entry_t;

    logic [3:0]    btn_level;
    logic [3:0]    btn_edge;
    logic          step_edge;
    logic          run_edge;
    logic          prev_edge;
    logic          next_edge;
    run_state_t    state;
    stop_cause_t   cause;
    logic [DW-1:0] div_cnt;
    logic          bkpt_hit;

    assign btn_level = {btn_next, btn_prev, btn_run, btn_step};

    edge_pulse #(
        .WIDTH(4)
    ) u_edge_pulse (
        .clk  (clk),
        .reset(reset),
        .level(btn_level),
        .pulse(btn_edge)
    );

    assign step_edge = btn_edge[0];
    assign run_edge  = btn_edge[1];
    assign prev_edge = btn_edge[2];
    assign next_edge = btn_edge[3];
    assign bkpt_hit  = cpu_valid_result && bkpt_en && (cpu_pc == bkpt_pc);

    // Faults preempt every other transition and latch until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cause       <= NONE;
            single_step <= 1'b0;
            running     <= 1'b0;
            div_cnt     <= '0;
        end else begin
            single_step <= 1'b0;
            if (cpu_halt || cpu_error) begin
                state   <= S_FAULT;
                cause   <= FAULT;
                running <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (step_edge) begin
                            single_step <= 1'b1;
                            state       <= S_STEP;
                        end else if (run_edge) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                            cause   <= NONE;
                            div_cnt <= '0;
                        end
                    end
                    S_STEP: begin
                        if (cpu_valid_result) begin
                            state <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        if (bkpt_hit) begin
                            state   <= S_IDLE;
                            running <= 1'b0;
                            cause   <= BKPT;
                        end else if (run_edge) begin
                            state   <= S_IDLE;
                            running <= 1'b0;
                            cause   <= USER;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt     <= '0;
                            single_step <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stop_cause = cause;

    trace_entry_t  trace_mem [DEPTH];
    trace_entry_t  rd_entry;
    logic [OW-1:0] wr_ptr;
    logic [OW-1:0] rd_idx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;

    always_ff @(posedge clk) begin
        if (cpu_valid_result) begin
            trace_mem[wr_ptr] <= '{pc: cpu_pc, instruction: cpu_instruction, result: cpu_result};
        end
    end

    assign count_after = (cpu_valid_result && count != CW'(DEPTH)) ? count + 1'b1 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            count       <= '0;
            new_result  <= 1'b0;
            view_offset <= '0;
        end else begin
            if (cpu_valid_result) begin
                wr_ptr     <= wr_ptr + 1'b1;
                new_result <= ~new_result;
            end
            count       <= count_after;
            view_offset <= OW'(next_view_offset(int'(view_offset), int'(count_after), DEPTH,
                                                cpu_valid_result, prev_edge, next_edge));
        end
    end

    // Offset 0 is the most recent write, so read one slot behind the write pointer.
    assign rd_idx   = wr_ptr - OW'(1) - view_offset;
    assign rd_entry = trace_mem[rd_idx];

    assign view_pc          = (count == '0) ? '0 : rd_entry.pc;
    assign view_instruction = (count == '0) ? '0 : rd_entry.instruction;
    assign view_result      = (count == '0) ? '0 : rd_entry.result;
    assign view_live        = (view_offset == '0);

endmodule
